// File: rtl/apb_gpio_irq_if.sv
// APB3 slave-side bus bundle for the GPIO block: request signals from the
// master, zero-wait-state response from the slave.
interface apb_gpio_irq_if;
  logic        apbi_psel;
  logic        apbi_penable;
  logic [31:0] apbi_paddr;
  logic        apbi_pwrite;
  logic [31:0] apbi_pwdata;
  logic [31:0] apbo_prdata;
  logic        apbo_pready;

  modport master (
    output apbi_psel, apbi_penable, apbi_paddr, apbi_pwrite, apbi_pwdata,
    input  apbo_prdata, apbo_pready
  );

  modport slave (
    input  apbi_psel, apbi_penable, apbi_paddr, apbi_pwrite, apbi_pwdata,
    output apbo_prdata, apbo_pready
  );
endinterface

// File: rtl/apb_gpio_irq.sv
// APB GPIO with input synchroniser, set/clear/toggle output helpers and
// per-pin edge (latched, W1C) or level (unlatched) interrupts.
module apb_gpio_irq #(
  parameter int               NBITS       = 8,
  parameter int               SYNC_STAGES = 2,
  parameter logic [NBITS-1:0] RESET_DIR   = '0
) (
  input  logic             clk,
  input  logic             rst,
  apb_gpio_irq_if.slave    apb,
  output logic             apbo_irq,
  input  logic [NBITS-1:0] gpioi_din,
  output logic [NBITS-1:0] gpioo_dout,
  output logic [NBITS-1:0] gpioo_oen
);

  localparam logic [3:0] A_DATA   = 4'd0;
  localparam logic [3:0] A_OUT    = 4'd1;
  localparam logic [3:0] A_DIR    = 4'd2;
  localparam logic [3:0] A_IMASK  = 4'd3;
  localparam logic [3:0] A_IPOL   = 4'd4;
  localparam logic [3:0] A_IEDGE  = 4'd5;
  localparam logic [3:0] A_IFLAG  = 4'd6;
  localparam logic [3:0] A_OUTSET = 4'd7;
  localparam logic [3:0] A_OUTCLR = 4'd8;
  localparam logic [3:0] A_OUTTGL = 4'd9;

  logic [NBITS-1:0] r_sync [SYNC_STAGES];
  logic [NBITS-1:0] r_out, r_dir, r_imask, r_ipol, r_iedge, r_iflag, r_prev;
  logic             r_irq;

  logic [3:0]       w_idx;
  logic             w_wr;
  logic [NBITS-1:0] w_wdata, w_data, w_rise, w_fall, w_set, w_clr, w_lvl;
  logic [NBITS-1:0] w_rd;
  logic             w_irq_next;
  logic             w_unused_bits;

  assign w_idx   = apb.apbi_paddr[5:2];
  assign w_wr    = apb.apbi_psel & apb.apbi_penable & apb.apbi_pwrite;
  assign w_wdata = apb.apbi_pwdata[NBITS-1:0];
  assign w_unused_bits = ^{apb.apbi_paddr[31:6], apb.apbi_paddr[1:0], apb.apbi_pwdata};

  // Pad synchroniser; stage 0 samples the asynchronous pins.
  generate
    for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      if (gi == 0) begin : g_first
        always_ff @(posedge clk) begin
          if (rst) r_sync[gi] <= '0;
          else     r_sync[gi] <= gpioi_din;
        end
      end else begin : g_next
        always_ff @(posedge clk) begin
          if (rst) r_sync[gi] <= '0;
          else     r_sync[gi] <= r_sync[gi-1];
        end
      end
    end
  endgenerate

  assign w_data = r_sync[SYNC_STAGES-1];
  assign w_rise = w_data & ~r_prev;
  assign w_fall = ~w_data & r_prev;
  assign w_set  = r_iedge & ((r_ipol & w_rise) | (~r_ipol & w_fall));
  assign w_clr  = (w_wr && w_idx == A_IFLAG) ? w_wdata : '0;
  assign w_lvl  = r_imask & ~r_iedge & ~(w_data ^ r_ipol);
  assign w_irq_next = (|(r_iflag & r_imask & r_iedge)) | (|w_lvl);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out   <= '0;
      r_dir   <= RESET_DIR;
      r_imask <= '0;
      r_ipol  <= '0;
      r_iedge <= '0;
      r_iflag <= '0;
      r_prev  <= '0;
      r_irq   <= 1'b0;
    end else begin
      r_prev  <= w_data;
      // A set event on the same bit outranks a simultaneous W1C.
      r_iflag <= (r_iflag & ~w_clr) | w_set;
      r_irq   <= w_irq_next;
      if (w_wr) begin
        case (w_idx)
          A_OUT:    r_out   <= w_wdata;
          A_DIR:    r_dir   <= w_wdata;
          A_IMASK:  r_imask <= w_wdata;
          A_IPOL:   r_ipol  <= w_wdata;
          A_IEDGE:  r_iedge <= w_wdata;
          A_OUTSET: r_out   <= r_out | w_wdata;
          A_OUTCLR: r_out   <= r_out & ~w_wdata;
          A_OUTTGL: r_out   <= r_out ^ w_wdata;
          default:  ;
        endcase
      end
    end
  end

  always_comb begin
    w_rd = '0;
    case (w_idx)
      A_DATA:  w_rd = w_data;
      A_OUT:   w_rd = r_out;
      A_DIR:   w_rd = r_dir;
      A_IMASK: w_rd = r_imask;
      A_IPOL:  w_rd = r_ipol;
      A_IEDGE: w_rd = r_iedge;
      A_IFLAG: w_rd = r_iflag;
      default: w_rd = '0;
    endcase
  end

  assign apb.apbo_prdata = (apb.apbi_psel & ~apb.apbi_pwrite) ? 32'(w_rd) : 32'd0;
  assign apb.apbo_pready = 1'b1;
  assign apbo_irq   = r_irq;
  assign gpioo_dout = r_out;
  assign gpioo_oen  = r_dir;

endmodule

// File: doc/apb_gpio_irq.md
APB_GPIO_IRQ -- requirements
Module: apb_gpio_irq

Interface
REQ-001 The block SHALL have parameter NBITS, default 8, meaning GPIO width, legal range 1..32.
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2, meaning input synchroniser depth, legal range 2..4.
REQ-003 The block SHALL have parameter RESET_DIR, default 0 (NBITS wide), meaning DIR register reset value.
REQ-004 clk  in  1  sole clock, all logic on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 apbi_psel  in  1  APB select.
REQ-007 apbi_penable  in  1  APB access phase.
REQ-008 apbi_paddr  in  32  byte address; only bits [5:2] decoded.
REQ-009 apbi_pwrite  in  1  1 = write.
REQ-010 apbi_pwdata  in  32  write data.
REQ-011 apbo_prdata  out  32  read data.
REQ-012 apbo_pready  out  1  tied 1 (zero wait states).
REQ-013 apbo_irq  out  1  registered, level, active-high interrupt.
REQ-014 gpioi_din  in  NBITS  asynchronous pad inputs.
REQ-015 gpioo_dout  out  NBITS  pad output values, equal to OUT register.
REQ-016 gpioo_oen  out  NBITS  pad output enables, equal to DIR register (1 = drive).

Function
REQ-017 Register map (byte offset):
- 0x00 DATA RO, synchronised input
- 0x04 OUT RW
- 0x08 DIR RW
- 0x0C IMASK RW
- 0x10 IPOL RW (1 = rising/high)
- 0x14 IEDGE RW (1 = edge, 0 = level)
- 0x18 IFLAG RO/W1C
- 0x1C OUTSET WO
- 0x20 OUTCLR WO
- 0x24 OUTTGL WO
REQ-018 A write SHALL commit on the clk edge where psel & penable & pwrite = 1; the new value is visible on outputs the following cycle.
REQ-019 apbo_prdata SHALL be combinational from psel & ~pwrite and address.
- bits [31:NBITS] read 0
- WO and unmapped offsets read 0
- writes to RO or unmapped offsets are ignored
REQ-020 OUTSET/OUTCLR/OUTTGL writes SHALL set/clear/invert OUT bits where pwdata is 1 and leave other bits unchanged.
REQ-021 gpioi_din SHALL pass through a SYNC_STAGES-deep flop chain; DATA = last stage, latency SYNC_STAGES cycles.
REQ-022 A register prev SHALL hold the previous DATA value.
- rise = DATA & ~prev
- fall = ~DATA & prev
REQ-023 IFLAG[i] SHALL set when IEDGE[i] = 1 and (IPOL[i] ? rise[i] : fall[i]); IMASK does not gate flag setting.
REQ-024 A W1C write to IFLAG SHALL clear bits written 1; a set event on the same bit in the same cycle SHALL win (flag remains 1).
REQ-025 Level term: lvl[i] = IMASK[i] & ~IEDGE[i] & (DATA[i] ~^ IPOL[i]); this term is not latched.
REQ-026 apbo_irq SHALL be registered: next value = |(IFLAG & IMASK & IEDGE) | |lvl. Latency from pin edge to apbo_irq = SYNC_STAGES + 2 cycles.
REQ-027 Changing IEDGE from 1 to 0 SHALL NOT clear IFLAG; stale flags remain readable but no longer drive the irq.

Reset
REQ-028 On rst = 1 at a clk edge, all of the following SHALL reset to 0:
- OUT, IMASK, IPOL, IEDGE, IFLAG
- sync chain, prev
- apbo_irq
DIR SHALL reset to RESET_DIR.
REQ-029 rst asserted during an APB access SHALL discard that write; reset takes priority over all register updates.
REQ-030 Since sync chain and prev reset to 0, the first cycles after reset may produce rise events; no IFLAG is set from them because IEDGE = 0.

Verification
REQ-031 Reset, NBITS=8: read every offset -> 0; gpioo_oen = RESET_DIR; apbo_irq = 0.
REQ-032 Write OUT = 0xA5, then OUTSET 0x0A, OUTCLR 0x81, OUTTGL 0xFF -> gpioo_dout sequence 0xA5, 0xAF, 0x2E, 0xD1; read OUT = 0xD1.
REQ-033 gpioi_din = 0x1234 with NBITS=8, SYNC_STAGES=2 -> DATA reads 0x00 one cycle after change and 0x34 after 2 cycles; bits [31:8] read 0.
REQ-034 IEDGE = IPOL = IMASK = 0x01, pin0 rises -> IFLAG = 0x01 at +3 cycles, apbo_irq = 1 at +4 cycles; W1C 0x01 -> irq = 0 two cycles later.
REQ-035 Edge on pin0 in the same cycle as a W1C of bit 0 -> IFLAG[0] stays 1.
REQ-036 Level mode: IEDGE = 0, IPOL = 0, IMASK = 0x02, pin1 = 0 -> apbo_irq = 1; drive pin1 = 1 -> apbo_irq = 0 after SYNC_STAGES + 1 cycles.
